// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor, Diff = A - B - Bin over WIDTH clocks
// One full-subtractor cell plus a registered borrow; valid/ready handshake on both sides.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic w_d;
  logic w_br_next;

  assign w_d       = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
  assign w_br_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_br    <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= A;
            r_b_sh  <= B;
            r_br    <= Bin;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_br   <= w_br_next;
          // Result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_bout  <= w_br_next;
            r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign Diff      = r_diff;
  assign Bout      = r_bout;
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=4)
// Expected {Bout,Ovf,Diff} queued at operand acceptance and popped on each output handshake.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  logic [5:0] sb_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] model(input int a, input int b, input int bin);
    int sa, sb, r;
    logic [3:0] d;
    logic bo, ov;
    d  = 4'((a - b - bin) & 15);
    bo = (a < b + bin);
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r  = sa - sb - bin;
    ov = (r < -8) || (r > 7);
    return {bo, ov, d};
  endfunction

  // Output side: choose out_ready for the coming edge, then score a handshake if one will occur.
  always @(negedge clk) begin
    if (ready_mode == 0) out_ready = 1'b0;
    else if (ready_mode == 1) out_ready = 1'b1;
    else out_ready = 1'($urandom_range(0, 1));
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_output", 1, 0);
      end else begin
        check("result", {26'd0, Bout, Ovf, Diff}, {26'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic send(input int a, input int b, input int bin);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("in_ready_timeout", 0, 1);
    A = 4'(a); B = 4'(b); Bin = 1'(bin);
    in_valid = 1'b1;
    sb_q.push_back(model(a, b, bin));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    int n;
    logic [5:0] e;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {Bout, Ovf, Diff}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic op with latency and release timing
    ready_mode = 1;
    send(9, 3, 0);
    wait_valid(n);
    check("latency_edges", n, 4);
    @(posedge clk);
    #1;
    check("in_ready_after_release", in_ready, 1);
    check("out_valid_after_release", out_valid, 0);

    send(3, 5, 0);
    send(0, 0, 1);
    send(7, 15, 0);
    send(8, 1, 0);
    drain();

    // Back-pressure: result must hold and new operands must be refused
    ready_mode = 0;
    send(5, 12, 1);
    e = model(5, 12, 1);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'(i % 2);
      A = 4'(i); B = 4'(15 - i);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {Bout, Ovf, Diff}, e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    ready_mode = 1;
    drain();

    // Asynchronous reset in the middle of RUN
    send(6, 2, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb_q.pop_back());
    #1;
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_diff", Diff, 0);
    check("midrun_rst_bout", Bout, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    send(15, 1, 0);
    drain();

    // Exhaustive sweep with random consumer back-pressure
    ready_mode = 2;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bin = 0; bin < 2; bin++)
          send(a, b, bin);
    drain();
    ready_mode = 1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
